mac_col_v2: RTL and testbench
=============================

MAC_COL_V2 -- requirements
Module: mac_col_v2

Interface
REQ-001 Parameter BW, 8, operand element width in bits.
REQ-002 Parameter PR, 8, lanes (elements) per query/key vector.
REQ-003 Parameter BW_PSUM, 2*BW+6, result width; the implementation SHALL satisfy BW_PSUM >= 2*BW+clog2(PR).
REQ-004 Parameter NUM_COL, 8, number of columns in the array.
REQ-005 Parameter COL_ID, 0, this column's index, 0..NUM_COL-1.
REQ-006 Parameter PIPE, 3, psum pipeline stages after the dot product, range 1..8.
REQ-007 Parameter SIGNED, 1: operands are two's complement; 0: operands are unsigned.
REQ-008 clk  input  1  clock, all state updates on rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 i_inst  input  3  instruction: [2] clear, [1] execute, [0] load.
REQ-011 q_in  input  PR*BW  query/key stream; lane i = bits [i*BW +: BW].
REQ-012 q_out  output  PR*BW  registered query, forwarded to the next column.
REQ-013 o_inst  output  3  registered i_inst, forwarded to the next column.
REQ-014 out  output  BW_PSUM  result (signed when SIGNED=1).
REQ-015 fifo_wr  output  1  one-cycle strobe: out is valid this cycle.
REQ-016 key_valid  output  1  key is captured and locked.

Function
REQ-017 Every cycle: o_inst <= i_inst; query_q <= q_in whenever i_inst[0] or i_inst[1] is set, else hold; q_out = query_q.
REQ-018 Key index KIDX = NUM_COL+1-COL_ID; load counter cnt has width clog2(NUM_COL+2).
REQ-019 On a load cycle with key_valid=0: if cnt==KIDX, key_q <= q_in, cnt <= 0, key_valid <= 1; else cnt <= cnt+1.
REQ-020 Load cycles with key_valid=1 SHALL update query_q only; key_q and cnt hold.
REQ-021 Clear (i_inst[2]) SHALL set key_valid=0 and cnt=0 next edge; key_q holds its old value; clear takes priority over load.
REQ-022 Dot product = sum over lanes of query_q[i]*key_q[i], with sign per SIGNED, sign/zero-extended to BW_PSUM with no truncation.
REQ-023 The dot product SHALL pass through exactly PIPE registers; an execute on i_inst in cycle n yields out and fifo_wr=1 in cycle n+1+PIPE.
REQ-024 fifo_wr SHALL be asserted only for executes issued while key_valid=1 (sampled with the query); executes without a key are dropped silently.
REQ-025 Back-to-back executes SHALL produce back-to-back fifo_wr strobes, one per execute, in order.
REQ-026 out SHALL hold its last value when fifo_wr=0.

Reset
REQ-027 Reset SHALL clear, asynchronously: out, q_out, o_inst, fifo_wr, key_valid, cnt, key_q, all pipeline registers and valid bits, and the accumulator.
REQ-028 Reset asserted mid-pipeline SHALL discard all in-flight results; no fifo_wr is produced for them after release.

Configuration
REQ-029 Macro MAC_COL_V2_ACC_EN defined: out = accumulator + pipelined dot product on each valid execute; accumulator wraps modulo 2^BW_PSUM; clear zeroes the accumulator.
REQ-030 MAC_COL_V2_ACC_EN undefined: out = pipelined dot product only; no accumulator register exists.

Structure
REQ-031 Shared package mac_pkg SHALL hold the instruction bit positions (INST_LOAD=0, INST_EXEC=1, INST_CLR=2) and the BW_PSUM width function.
REQ-032 The dot product SHALL be a sub-module mac_dot_pr (PR lanes, SIGNED, combinational), instantiated once.

Verification
REQ-033 COL_ID=0, NUM_COL=8: loads carrying values 1..10 -> key_valid rises after load 10 (cnt==9); key = vector 10.
REQ-034 Key all lanes 3, query all lanes -2, SIGNED=1, PR=8, one execute at cycle n -> out=-48 with fifo_wr=1 only at cycle n+4 (PIPE=3).
REQ-035 Execute issued before the key is valid -> no fifo_wr strobe; o_inst and q_out still forwarded after 1 cycle.
REQ-036 Four back-to-back executes -> four consecutive fifo_wr strobes; with MAC_COL_V2_ACC_EN, out = running sum; clear then execute -> accumulator restarts from 0.
REQ-037 Reset pulsed 1 cycle after an execute -> all outputs 0, no fifo_wr afterwards; clear+load issued together -> key_valid=0, cnt=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC column: instruction bit positions and psum width helpers.
package mac_pkg;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int INST_CLR  = 2;

    function automatic int psum_width(input int bw);
        return 2 * bw + 6;
    endfunction

    // Narrowest result that can hold a full PR-lane dot product without truncation.
    function automatic int min_psum_width(input int bw, input int pr);
        return 2 * bw + $clog2(pr);
    endfunction

endpackage

// File: rtl/mac_dot_pr.sv
// Combinational PR-lane dot product, lanes signed or unsigned per SIGNED, full-width sum.
module mac_dot_pr #(
    parameter int BW      = 8,
    parameter int PR      = 8,
    parameter int BW_PSUM = 22,
    parameter int SIGNED  = 1
) (
    input  logic [PR*BW-1:0]  a_i,
    input  logic [PR*BW-1:0]  b_i,
    output logic [BW_PSUM-1:0] dot_o
);

    localparam int PW = 2 * BW + 2;

    logic signed [BW:0]   a_x;
    logic signed [BW:0]   b_x;
    logic signed [PW-1:0] prod;

    // One extra bit per operand lets a single signed multiply cover both modes.
    always_comb begin
        dot_o = '0;
        a_x   = '0;
        b_x   = '0;
        prod  = '0;
        for (int i = 0; i < PR; i++) begin
            a_x   = {(SIGNED != 0) & a_i[i*BW+BW-1], a_i[i*BW +: BW]};
            b_x   = {(SIGNED != 0) & b_i[i*BW+BW-1], b_i[i*BW +: BW]};
            prod  = PW'(a_x) * PW'(b_x);
            dot_o = dot_o + BW_PSUM'(prod);
        end
    end

endmodule

// File: rtl/mac_col_v2.sv
// One column of the MAC array: key capture, query forwarding, pipelined dot product.
// Optional accumulate mode enabled by defining MAC_COL_V2_ACC_EN.
module mac_col_v2
    import mac_pkg::*;
#(
    parameter int BW      = 8,
    parameter int PR      = 8,
    parameter int BW_PSUM = psum_width(BW),
    parameter int NUM_COL = 8,
    parameter int COL_ID  = 0,
    parameter int PIPE    = 3,
    parameter int SIGNED  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         i_inst,
    input  logic [PR*BW-1:0]   q_in,
    output logic [PR*BW-1:0]   q_out,
    output logic [2:0]         o_inst,
    output logic [BW_PSUM-1:0] out,
    output logic               fifo_wr,
    output logic               key_valid
);

    localparam int CW = $clog2(NUM_COL + 2);
    localparam logic [CW-1:0] KIDX = CW'(NUM_COL + 1 - COL_ID);

    if (BW_PSUM < min_psum_width(BW, PR)) begin : g_bad_width
        $error("mac_col_v2: BW_PSUM too narrow for BW/PR");
    end

    logic [PR*BW-1:0]   query_q;
    logic [PR*BW-1:0]   key_q;
    logic [CW-1:0]      cnt_q;
    logic               key_valid_q;
    logic [2:0]         inst_q;
    logic               exec_vld_q;
    logic [BW_PSUM-1:0] dot;

    logic [BW_PSUM-1:0] pipe_q  [PIPE];
    logic [BW_PSUM-1:0] stage_d [PIPE];
    logic [PIPE-1:0]    pvld_q;
    logic [PIPE-1:0]    svld_d;
    logic [BW_PSUM-1:0] last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q      <= '0;
            query_q     <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            exec_vld_q  <= 1'b0;
        end else begin
            inst_q <= i_inst;
            if (i_inst[INST_LOAD] | i_inst[INST_EXEC])
                query_q <= q_in;
            if (i_inst[INST_CLR]) begin
                cnt_q       <= '0;
                key_valid_q <= 1'b0;
            end else if (i_inst[INST_LOAD] && !key_valid_q) begin
                if (cnt_q == KIDX) begin
                    key_q       <= q_in;
                    cnt_q       <= '0;
                    key_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            // Key validity is sampled alongside the query so a later clear cannot drop it.
            exec_vld_q <= i_inst[INST_EXEC] & key_valid_q;
        end
    end

    mac_dot_pr #(
        .BW      (BW),
        .PR      (PR),
        .BW_PSUM (BW_PSUM),
        .SIGNED  (SIGNED)
    ) u_dot (
        .a_i   (query_q),
        .b_i   (key_q),
        .dot_o (dot)
    );

    always_comb begin
        stage_d[0] = dot;
        svld_d[0]  = exec_vld_q;
        for (int k = 1; k < PIPE; k++) begin
            stage_d[k] = pipe_q[k-1];
            svld_d[k]  = pvld_q[k-1];
        end
    end

`ifdef MAC_COL_V2_ACC_EN
    logic [BW_PSUM-1:0] acc_q;

    assign last_d = acc_q + stage_d[PIPE-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else if (i_inst[INST_CLR])
            acc_q <= '0;
        else if (svld_d[PIPE-1])
            acc_q <= last_d;
    end
`else
    assign last_d = stage_d[PIPE-1];
`endif

    // Stages load only on valid so the final stage holds the last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE; k++)
                pipe_q[k] <= '0;
            pvld_q <= '0;
        end else begin
            pvld_q <= svld_d;
            for (int k = 0; k < PIPE; k++) begin
                if (svld_d[k])
                    pipe_q[k] <= (k == PIPE - 1) ? last_d : stage_d[k];
            end
        end
    end

    assign out       = pipe_q[PIPE-1];
    assign fifo_wr   = pvld_q[PIPE-1];
    assign key_valid = key_valid_q;
    assign q_out     = query_q;
    assign o_inst    = inst_q;

endmodule

// File: tb/tb_mac_col_v2.sv
// Directed bench for mac_col_v2 with a timed scoreboard of expected results.
module tb_mac_col_v2;

    localparam int BW      = 8;
    localparam int PR      = 8;
    localparam int BW_PSUM = 22;
    localparam int NUM_COL = 8;
    localparam int COL_ID  = 0;
    localparam int PIPE    = 3;
    localparam int SIGNED  = 1;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] EXEC = 3'b010;
    localparam logic [2:0] CLR  = 3'b100;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         i_inst;
    logic [PR*BW-1:0]   q_in;
    logic [PR*BW-1:0]   q_out;
    logic [2:0]         o_inst;
    logic [BW_PSUM-1:0] out;
    logic               fifo_wr;
    logic               key_valid;

    mac_col_v2 #(
        .BW(BW), .PR(PR), .BW_PSUM(BW_PSUM), .NUM_COL(NUM_COL),
        .COL_ID(COL_ID), .PIPE(PIPE), .SIGNED(SIGNED)
    ) dut (
        .clk(clk), .reset(reset), .i_inst(i_inst), .q_in(q_in),
        .q_out(q_out), .o_inst(o_inst), .out(out),
        .fifo_wr(fifo_wr), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [BW_PSUM-1:0] val;
        int                 due;
    } exp_t;
    exp_t sb[$];

    logic               kv;
    int                 cnt_m;
    logic [63:0]        key_m;
    logic [BW_PSUM-1:0] acc_m;
    logic [BW_PSUM-1:0] last_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] splat(input int v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [BW_PSUM-1:0] dotf(input logic [63:0] a, input logic [63:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += $signed(a[i*8 +: 8]) * $signed(b[i*8 +: 8]);
        return BW_PSUM'(s);
    endfunction

    // Drive one instruction for one cycle and advance the reference model.
    task automatic step(input logic [2:0] inst, input logic [63:0] q);
        logic [BW_PSUM-1:0] v;
        i_inst = inst;
        q_in   = q;
        if (inst[1] && kv) begin
            v = dotf(q, key_m);
`ifdef MAC_COL_V2_ACC_EN
            v = acc_m + v;
            acc_m = v;
`endif
            sb.push_back('{v, cyc + 1 + PIPE});
            last_val = v;
        end
        if (inst[2]) begin
            kv = 1'b0;
            cnt_m = 0;
            acc_m = '0;
        end else if (inst[0] && !kv) begin
            if (cnt_m == NUM_COL + 1 - COL_ID) begin
                key_m = q;
                cnt_m = 0;
                kv = 1'b1;
            end else begin
                cnt_m++;
            end
        end
        @(posedge clk);
        #1;
        i_inst = 3'b000;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(3'b000, q_in);
        step(3'b000, q_in);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out"}, 64'(out), 64'd0);
        chk({tag, "_q_out"}, q_out, 64'd0);
        chk({tag, "_o_inst"}, 64'(o_inst), 64'd0);
        chk({tag, "_fifo_wr"}, 64'(fifo_wr), 64'd0);
        chk({tag, "_key_valid"}, 64'(key_valid), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_fifo_wr", 64'(fifo_wr), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out", 64'(out), 64'(e.val));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin : main
        logic [63:0] keyr;
        reset = 1'b1; i_inst = 3'b000; q_in = '0;
        kv = 1'b0; cnt_m = 0; key_m = '0; acc_m = '0; last_val = '0;
        #2;
        chk_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Execute without a key: forwarded, but no result
        step(EXEC, splat(5));
        chk("o_inst_fwd", 64'(o_inst), 64'(EXEC));
        chk("q_out_fwd", q_out, splat(5));
        repeat (6) step(3'b000, q_in);

        for (int v = 1; v <= 10; v++) begin
            step(LOAD, splat(v));
            chk("key_valid_load", 64'(key_valid), 64'(v == 10));
        end
        step(LOAD, splat(99));
        chk("q_out_locked_load", q_out, splat(99));
        chk("key_valid_locked", 64'(key_valid), 64'd1);
        step(EXEC, splat(2));
        drain();
        chk("out_hold", 64'(out), 64'(last_val));

        // Clear has priority over a simultaneous load
        step(CLR | LOAD, splat(7));
        chk("key_valid_clr_load", 64'(key_valid), 64'd0);
        chk("cnt_clr_load", 64'(dut.cnt_q), 64'd0);
        for (int v = 1; v <= 10; v++) begin
            step(LOAD, (v == 10) ? splat(3) : splat(v + 20));
            chk("key_valid_reload", 64'(key_valid), 64'(v == 10));
        end
        step(EXEC, splat(-2));
        drain();

        for (int i = 0; i < 4; i++) step(EXEC, {$urandom, $urandom});
        drain();

        // Clear, re-key with mixed lanes, execute again
        step(CLR, q_in);
        keyr = {$urandom, $urandom};
        for (int v = 1; v <= 10; v++) step(LOAD, (v == 10) ? keyr : splat(v));
        step(EXEC, {$urandom, $urandom});
        step(EXEC, splat(-128));
        drain();

        // Reset one cycle after an execute discards it
        step(EXEC, splat(1));
        reset = 1'b1;
        #1;
        chk_zero_outputs("mid_reset");
        sb.delete();
        kv = 1'b0; cnt_m = 0; acc_m = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) step(3'b000, q_in);
        chk("key_valid_after_reset", 64'(key_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
